crt_timing_controller: RTL and testbench
========================================

Name: crt_timing_controller

Overview:
- Sequences the CRT/VGA raster from the 25 MHz pixel-rate enable produced by the CRT clock generator.
- Runs horizontal and vertical counters and drives HSync/VSync/VideoOn and the pixel coordinates consumed by the game renderer.
- Starts and stops display scan on whole-frame boundaries under an Enable request, so the renderer never sees a partial frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of HSync/VSync while asserted (0 = active-low)

Ports:
CLK  input  1  system clock; the only clock
RESET  input  1  synchronous, active-high reset
PixelTick  input  1  one-CLK-wide pixel-rate enable from the CRT clock generator
Enable  input  1  level request to scan; sampled only at frame boundaries
HSync  output  1  horizontal sync
VSync  output  1  vertical sync
VideoOn  output  1  high while (PixelX, PixelY) is in the visible area
PixelX  output  10  horizontal count, 0..H_TOTAL-1
PixelY  output  10  vertical count, 0..V_TOTAL-1
LineStart  output  1  one-CLK pulse on the tick where PixelX wraps to 0
FrameStart  output  1  one-CLK pulse on the tick where PixelX and PixelY both become 0
Busy  output  1  high while a frame is being scanned

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset:
  - State IDLE; PixelX = PixelY = 0.
  - HSync = VSync = ~SYNC_ACTIVE; VideoOn, LineStart, FrameStart and Busy all 0.
  - Reset overrides PixelTick and Enable in the same cycle, including mid-frame.
- Counters change only on CLK edges where PixelTick = 1. Between ticks every output holds, except the strobes, which return to 0.
- PixelX:
  - Increments each tick.
  - At H_TOTAL-1 it wraps to 0 and PixelY increments.
  - PixelY wraps from V_TOTAL-1 to 0.
- Outputs are registered and decoded from the next counter values, so they are aligned with PixelX/PixelY with zero extra latency:
  - HSync = SYNC_ACTIVE iff H_ACTIVE+H_FRONT <= PixelX < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - VSync = SYNC_ACTIVE iff V_ACTIVE+V_FRONT <= PixelY < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - VideoOn = 1 iff PixelX < H_ACTIVE and PixelY < V_ACTIVE and state != IDLE.
- State machine:
  - IDLE: counters held at 0, syncs inactive, Busy = 0. Moves to RUN on the first PixelTick with Enable = 1; that tick emits FrameStart and LineStart, and the counters stay at (0,0).
  - RUN: Busy = 1; counters advance. If Enable = 0 on any tick, move to DRAIN without disturbing the counters.
  - DRAIN: scanning continues exactly as in RUN until the frame wrap tick (PixelX = H_TOTAL-1, PixelY = V_TOTAL-1).
    - At the wrap: if Enable = 1, return to RUN, emit FrameStart, and continue with no gap.
    - At the wrap: if Enable = 0, go to IDLE, counters = (0,0), Busy drops on that edge, and no FrameStart is emitted.
  - RUN at the frame wrap with Enable = 1 emits FrameStart (plus LineStart) and continues.
- Simultaneous events:
  - Enable falling on the wrap tick in RUN: treat as RUN -> DRAIN -> IDLE resolved in one step, i.e. go directly to IDLE.
  - PixelTick with RESET: reset wins.
- Arithmetic: counters are 10-bit unsigned, so H_TOTAL and V_TOTAL must be <= 1024. No saturation; wrap occurs only at the TOTAL boundary.

Decomposition:
- Shared package: crt_timing_pkg holds the timing constants (640x480@60 default set), H_TOTAL/V_TOTAL computation, and the state encoding IDLE/RUN/DRAIN.
- One natural sub-module: crt_axis_counter (count, wrap pulse, sync/active window decode), instantiated once for horizontal and once for vertical. The vertical instance is enabled by the horizontal wrap pulse.

Test Plan:
- Reset and start: CLK 100 MHz, PixelTick every 4th CLK, RESET high 2 cycles then low, Enable = 1.
  - Busy rises on the first tick, with FrameStart = 1 and PixelX = PixelY = 0.
  - Exactly 800 ticks later: LineStart, PixelY = 1.
- Horizontal timing: on line 0, HSync = 0 for exactly 96 ticks, starting at PixelX = 656 and released at PixelX = 752. VideoOn = 1 for PixelX 0..639 only.
- Vertical timing and frame period:
  - VSync = 0 only for PixelY 490..491.
  - VideoOn = 0 for PixelY >= 480.
  - Consecutive FrameStart pulses exactly 420000 ticks (1680000 CLK) apart.
- Graceful stop: drop Enable at PixelY = 100.
  - Scan continues to (799,524), then goes IDLE with (0,0) and Busy = 0.
  - No further FrameStart; re-asserting Enable restarts at the next tick.
- Enable glitch in DRAIN: drop Enable at line 200, raise it at line 300.
  - Frame continues uninterrupted and the next FrameStart arrives 420000 ticks after the previous one.
- Mid-frame reset: assert RESET at PixelX = 400, PixelY = 250, coincident with a PixelTick.
  - Next cycle shows all reset values: HSync = VSync = 1, Busy = 0, counters 0.

Source files
------------

// File: rtl/crt_timing_pkg.sv
// rtl/crt_timing_pkg.sv - shared raster timing constants, state encoding and helpers
package crt_timing_pkg;

  // 640x480@60 default raster
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam logic DEF_SYNC_ACTIVE = 1'b0;

  // Counter width; both axis totals must fit in it
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Total count of one axis (active + porches + sync)
  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/crt_timing_if.sv
// rtl/crt_timing_if.sv - raster control and timing output bundle
interface crt_timing_if;
  logic       PixelTick;
  logic       Enable;
  logic       HSync;
  logic       VSync;
  logic       VideoOn;
  logic [9:0] PixelX;
  logic [9:0] PixelY;
  logic       LineStart;
  logic       FrameStart;
  logic       Busy;

  // Timing controller side: consumes tick/enable, produces the raster
  modport master (
    input  PixelTick, Enable,
    output HSync, VSync, VideoOn, PixelX, PixelY, LineStart, FrameStart, Busy
  );

  // Clock generator / renderer side
  modport slave (
    output PixelTick, Enable,
    input  HSync, VSync, VideoOn, PixelX, PixelY, LineStart, FrameStart, Busy
  );
endinterface

// File: rtl/crt_axis_counter.sv
// rtl/crt_axis_counter.sv - one raster axis: counter, wrap detect, sync/active window decode
module crt_axis_counter
  import crt_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             at_last,
  output logic             in_sync,
  output logic             in_active
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] count_next;

  assign at_last = (count == LAST);

  // Next count: clear holds at zero, step advances and wraps only at TOTAL-1
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (step) begin
      count_next = at_last ? '0 : count + CNT_W'(1);
    end
  end

  // Window flags are decoded from the next count so they line up with count
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      in_sync   <= 1'b0;
      in_active <= 1'b1;
    end else begin
      count     <= count_next;
      in_sync   <= (count_next >= SYNC_LO) && (count_next < SYNC_HI);
      in_active <= (count_next < ACT_END);
    end
  end

endmodule

// File: rtl/crt_timing_controller.sv
// rtl/crt_timing_controller.sv - CRT raster sequencer with whole-frame start/stop
module crt_timing_controller
  import crt_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic         CLK,
  input  logic         RESET,
  crt_timing_if.master bus
);

  state_t state, state_next;
  logic   h_step, v_step, clear;
  logic   h_last, v_last, frame_last;
  logic   h_sync_win, v_sync_win, h_act_win, v_act_win;
  logic   line_pulse, frame_pulse;
  logic   line_start_q, frame_start_q;
  logic [CNT_W-1:0] h_count, v_count;

  // Counters are pinned at zero while idle and only move on pixel ticks
  assign clear      = (state == ST_IDLE);
  assign h_step     = bus.PixelTick && (state != ST_IDLE);
  assign v_step     = h_step && h_last;
  assign frame_last = h_last && v_last;

  crt_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(CLK), .reset(RESET), .step(h_step), .clear(clear),
    .count(h_count), .at_last(h_last), .in_sync(h_sync_win), .in_active(h_act_win)
  );

  crt_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(CLK), .reset(RESET), .step(v_step), .clear(clear),
    .count(v_count), .at_last(v_last), .in_sync(v_sync_win), .in_active(v_act_win)
  );

  // Next state and strobe decode; Enable only matters at frame boundaries
  always_comb begin
    state_next  = state;
    line_pulse  = 1'b0;
    frame_pulse = 1'b0;
    if (bus.PixelTick) begin
      case (state)
        ST_IDLE: begin
          if (bus.Enable) begin
            state_next  = ST_RUN;
            line_pulse  = 1'b1;
            frame_pulse = 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (frame_last) begin
            // A stop pending (DRAIN) or requested on this very tick ends here
            if (bus.Enable) begin
              state_next  = ST_RUN;
              line_pulse  = 1'b1;
              frame_pulse = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            line_pulse = h_last;
            if ((state == ST_RUN) && !bus.Enable) begin
              state_next = ST_DRAIN;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register and one-CLK strobes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_next;
      line_start_q  <= line_pulse;
      frame_start_q <= frame_pulse;
    end
  end

  assign bus.PixelX     = h_count;
  assign bus.PixelY     = v_count;
  assign bus.Busy       = (state != ST_IDLE);
  assign bus.HSync      = h_sync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign bus.VSync      = v_sync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign bus.VideoOn    = h_act_win && v_act_win && (state != ST_IDLE);
  assign bus.LineStart  = line_start_q;
  assign bus.FrameStart = frame_start_q;

endmodule

// File: tb/tb_crt_timing_controller.sv
// tb/tb_crt_timing_controller.sv - scoreboard bench for crt_timing_controller on a reduced raster
module tb_crt_timing_controller;

  // Reduced raster: H 16+2+4+3 = 25, V 12+2+2+3 = 19, frame = 475 ticks
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = 1900;  // 475 ticks at one tick per 4 CLK

  typedef logic [25:0] exp_t;  // busy,fs,ls,von,vs,hs,y[9:0],x[9:0]

  logic CLK;
  logic RESET;
  crt_timing_if bus ();

  crt_timing_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  // Reference raster: state 0 idle, 1 run, 2 drain
  int   mst = 0, mx = 0, my = 0;
  logic mls = 1'b0, mfs = 1'b0;
  int   cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic model(input logic tk, input logic en, input logic rst);
    logic hl, fl;
    mls = 1'b0;
    mfs = 1'b0;
    if (rst) begin
      mst = 0; mx = 0; my = 0;
    end else if (tk) begin
      if (mst == 0) begin
        if (en) begin mst = 1; mls = 1'b1; mfs = 1'b1; end
      end else begin
        hl = (mx == HT - 1);
        fl = hl && (my == VT - 1);
        if (hl) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
        if (fl) begin
          if (en) begin mst = 1; mls = 1'b1; mfs = 1'b1; end
          else mst = 0;
        end else begin
          mls = hl;
          if (mst == 1 && !en) mst = 2;
        end
      end
    end
  endtask

  function automatic exp_t expected();
    logic hs, vs, von, busy;
    hs   = (mx >= HA + HF && mx < HA + HF + HS) ? 1'b0 : 1'b1;
    vs   = (my >= VA + VF && my < VA + VF + VS) ? 1'b0 : 1'b1;
    busy = (mst != 0);
    von  = (mx < HA) && (my < VA) && busy;
    return {busy, mfs, mls, von, vs, hs, 10'(my), 10'(mx)};
  endfunction

  // One CLK: drive inputs, record what the edge must produce
  task automatic step(input logic en, input logic rst);
    logic tk;
    tk = ((cyc % 4) == 3);
    bus.PixelTick = tk;
    bus.Enable    = en;
    RESET         = rst;
    model(tk, en, rst);
    exp_q.push_back(expected());
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_ticks(input int n, input logic en);
    int t;
    t = 0;
    while (t < n) begin
      if ((cyc % 4) == 3) t++;
      step(en, 1'b0);
    end
  endtask

  task automatic run_until_y(input int y, input logic en);
    int b;
    b = 0;
    while (my != y && b < 4 * FRAME_CLKS) begin
      step(en, 1'b0);
      b++;
    end
    check("wait_line_timeout", 64'(my), 64'(y));
  endtask

  // Monitor: one expected raster word per CLK, plus frame period on the pulses
  int   per = 0;
  logic have_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e, got;
    got = {bus.Busy, bus.FrameStart, bus.LineStart, bus.VideoOn, bus.VSync, bus.HSync,
           bus.PixelY, bus.PixelX};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("raster", 64'(got), 64'(e));
    end
    if (!bus.Busy) begin
      have_prev = 1'b0;
      per = 0;
    end else begin
      per++;
      if (bus.FrameStart) begin
        if (have_prev) check("frame_period", 64'(per), 64'(FRAME_CLKS));
        have_prev = 1'b1;
        per = 0;
      end
    end
  end

  initial begin
    int b;
    bus.PixelTick = 1'b0;
    bus.Enable    = 1'b1;
    RESET         = 1'b1;

    // Reset, then start and run two full frames plus a bit
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    run_ticks(2 * HT * VT + 30, 1'b1);

    // Graceful stop mid-frame, idle a while, then restart
    run_until_y(5, 1'b1);
    b = 0;
    while (mst != 0 && b < 4 * FRAME_CLKS) begin
      step(1'b0, 1'b0);
      b++;
    end
    check("drain_timeout", 64'(mst), 64'(0));
    run_ticks(20, 1'b0);
    run_ticks(HT * VT + 10, 1'b1);

    // Enable glitch while draining: the frame must not be disturbed
    run_until_y(4, 1'b1);
    run_until_y(8, 1'b0);
    run_ticks(HT * VT + 150, 1'b1);

    // Reset mid-frame coincident with a tick
    b = 0;
    while (!(mx == 10 && my == 6 && (cyc % 4) == 3) && b < 4 * FRAME_CLKS) begin
      step(1'b1, 1'b0);
      b++;
    end
    check("reset_point_timeout", 64'({mx[15:0], my[15:0]}), 64'({16'd10, 16'd6}));
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    run_ticks(40, 1'b1);

    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
